// File: rtl/vscale_iter_mul_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vscale_iter_mul_div_pkg
//  Purpose  : Shared widths, operation encodings, FSM state type and the
//             conditional absolute-value helper for the iterative mul/div unit.
//  Revision : 1.0 - initial release
// ============================================================================
package vscale_iter_mul_div_pkg;

    localparam int XPR_LEN          = 32;
    localparam int MD_OP_WIDTH      = 2;
    localparam int MD_OUT_SEL_WIDTH = 1;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO = 1'b0;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI = 1'b1;

    typedef enum logic [1:0] {
        MD_STATE_IDLE    = 2'd0,
        MD_STATE_COMPUTE = 2'd1,
        MD_STATE_DONE    = 2'd2
    } md_state_e;

    // Magnitude of an operand; only negative when treated as signed.
    function automatic logic [XPR_LEN-1:0] md_abs(input logic [XPR_LEN-1:0] x,
                                                  input logic              is_signed);
        return (is_signed && x[XPR_LEN-1]) ? -x : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vscale_iter_mul_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : vscale_iter_mul_div_if
//  Purpose  : Request/response bundle between the execute-stage control
//             (master) and the iterative mul/div unit (slave).
//  Ports    : req_* valid/ready request with operands and controls,
//             kill abort, resp_valid/resp_result one-cycle response.
//  Revision : 1.0 - initial release
// ============================================================================
interface vscale_iter_mul_div_if;
    import vscale_iter_mul_div_pkg::*;

    logic                        req_valid;
    logic                        req_ready;
    logic [MD_OP_WIDTH-1:0]      req_op;
    logic                        req_in_1_signed;
    logic                        req_in_2_signed;
    logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel;
    logic [XPR_LEN-1:0]          req_in_1;
    logic [XPR_LEN-1:0]          req_in_2;
    logic                        kill;
    logic                        resp_valid;
    logic [XPR_LEN-1:0]          resp_result;

    modport master (
        output req_valid, req_op, req_in_1_signed, req_in_2_signed,
               req_out_sel, req_in_1, req_in_2, kill,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_in_1_signed, req_in_2_signed,
               req_out_sel, req_in_1, req_in_2, kill,
        output req_ready, resp_valid, resp_result
    );

endinterface
`default_nettype wire

// File: rtl/vscale_iter_mul_div.sv
`default_nettype none
// ============================================================================
//  Module   : vscale_iter_mul_div
//  Purpose  : Iterative RV32M multiply/divide. Operands are reduced to
//             magnitudes on accept, processed one bit per cycle for 32
//             cycles (shift-add multiply / restoring divide), then the sign
//             is reapplied and the result presented for one cycle.
//  Ports    : clk      - clock, rising edge
//             reset_n  - asynchronous active-low reset
//             md       - slave side of the request/response bundle
//  Revision : 1.0 - initial release
// ============================================================================
module vscale_iter_mul_div
    import vscale_iter_mul_div_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset_n,
    vscale_iter_mul_div_if.slave  md
);

    md_state_e                   r_state;
    md_state_e                   w_state_next;
    logic                        w_req_ready;
    logic                        w_resp_valid;

    logic [4:0]                  r_count;
    logic [MD_OP_WIDTH-1:0]      r_op;
    logic [MD_OUT_SEL_WIDTH-1:0] r_out_sel;
    logic                        r_negate;

    logic [2*XPR_LEN-1:0]        r_mcand;
    logic [XPR_LEN-1:0]          r_mplier;
    logic [2*XPR_LEN-1:0]        r_prod;
    logic [XPR_LEN-1:0]          r_divisor;
    logic [XPR_LEN-1:0]          r_quo;
    logic [XPR_LEN-1:0]          r_rem;
    logic [XPR_LEN-1:0]          r_result;

    logic                        w_accept;
    logic                        w_sign_1;
    logic                        w_sign_2;
    logic                        w_negate_req;
    logic                        w_last;
    logic [2*XPR_LEN-1:0]        w_prod_next;
    logic [XPR_LEN:0]            w_shifted;
    logic                        w_q_bit;
    logic [XPR_LEN-1:0]          w_rem_next;
    logic [XPR_LEN-1:0]          w_quo_next;
    logic [2*XPR_LEN-1:0]        w_raw;
    logic [2*XPR_LEN-1:0]        w_fixed;
    logic [XPR_LEN-1:0]          w_final;

    // Kill has priority over a simultaneous request.
    assign w_accept = md.req_valid && (r_state == MD_STATE_IDLE) && !md.kill;
    assign w_sign_1 = md.req_in_1_signed && md.req_in_1[XPR_LEN-1];
    assign w_sign_2 = md.req_in_2_signed && md.req_in_2[XPR_LEN-1];
    assign w_last   = (r_state == MD_STATE_COMPUTE) && (r_count == 5'd31);

    // A zero divisor must not negate the all-ones quotient.
    always_comb begin
        w_negate_req = 1'b0;
        case (md.req_op)
            MD_OP_MUL: w_negate_req = w_sign_1 ^ w_sign_2;
            MD_OP_DIV: w_negate_req = (w_sign_1 ^ w_sign_2) && (md.req_in_2 != '0);
            default:   w_negate_req = w_sign_1;
        endcase
    end

    // One iteration of both datapaths; only the one matching r_op matters.
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_shifted   = {r_rem, r_quo[XPR_LEN-1]};
    assign w_q_bit     = (w_shifted >= {1'b0, r_divisor});
    // The restored difference is always below 2^32, so a 32-bit subtract is exact.
    assign w_rem_next  = w_q_bit ? (w_shifted[XPR_LEN-1:0] - r_divisor)
                                 : w_shifted[XPR_LEN-1:0];
    assign w_quo_next  = {r_quo[XPR_LEN-2:0], w_q_bit};

    // Single shared 64-bit negator; the low half of a negated zero-extended
    // word equals the 32-bit negation.
    always_comb begin
        w_raw = '0;
        case (r_op)
            MD_OP_MUL: w_raw = w_prod_next;
            MD_OP_DIV: w_raw = {{XPR_LEN{1'b0}}, w_quo_next};
            default:   w_raw = {{XPR_LEN{1'b0}}, w_rem_next};
        endcase
        w_fixed = r_negate ? -w_raw : w_raw;
        w_final = ((r_op == MD_OP_MUL) && (r_out_sel == MD_OUT_HI))
                  ? w_fixed[2*XPR_LEN-1:XPR_LEN] : w_fixed[XPR_LEN-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MD_STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            MD_STATE_IDLE: begin
                w_req_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = MD_STATE_COMPUTE;
                end
            end
            MD_STATE_COMPUTE: begin
                if (md.kill) begin
                    w_state_next = MD_STATE_IDLE;
                end else if (r_count == 5'd31) begin
                    w_state_next = MD_STATE_DONE;
                end
            end
            MD_STATE_DONE: begin
                w_resp_valid = 1'b1;
                w_state_next = MD_STATE_IDLE;
            end
            default: begin
                w_state_next = MD_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_op      <= MD_OP_MUL;
            r_out_sel <= MD_OUT_LO;
            r_negate  <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_op      <= md.req_op;
            r_out_sel <= md.req_out_sel;
            r_negate  <= w_negate_req;
            r_mcand   <= {{XPR_LEN{1'b0}}, md_abs(md.req_in_1, md.req_in_1_signed)};
            r_mplier  <= md_abs(md.req_in_2, md.req_in_2_signed);
            r_prod    <= '0;
            r_divisor <= md_abs(md.req_in_2, md.req_in_2_signed);
            r_quo     <= md_abs(md.req_in_1, md.req_in_1_signed);
            r_rem     <= '0;
        end else if ((r_state == MD_STATE_COMPUTE) && !md.kill) begin
            r_count  <= r_count + 5'd1;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= w_prod_next;
            r_quo    <= w_quo_next;
            r_rem    <= w_rem_next;
            // Capture the signed result on the edge that enters DONE.
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign md.req_ready   = w_req_ready;
    assign md.resp_valid  = w_resp_valid;
    assign md.resp_result = r_result;

endmodule
`default_nettype wire
